vgacon_tty_ctrl: RTL and testbench

Terminal-style sequencer that turns a byte stream into writes on the VGA console text buffer's write port. It tracks a cursor, handles control codes, and runs multi-cycle scroll and clear sequences through the buffer's read and write ports. It sits between the TinyQV peripheral register interface (or a UART RX path) and the NUM_ROWS x NUM_COLS text/colour buffer that the VGA scan-out reads.

---
 rtl/vgacon_tty_ctrl_if.sv | 43 ++++
 rtl/vgacon_tty_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vgacon_tty_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vgacon_tty_ctrl_if.sv
// ---------------------------------------------------------------------------
// vgacon_tty_ctrl_if
// Bundles the byte-stream handshake and the text-buffer read/write port used
// by vgacon_tty_ctrl.
//   in_valid/in_data/in_color/in_ready : byte source -> controller handshake
//   buf_we/buf_waddr/buf_wchar/buf_wcolor : controller -> buffer write port
//   buf_raddr                            : controller -> buffer read address
//   buf_rchar/buf_rcolor                 : buffer -> controller read data
//                                          (combinational, same cycle)
// Modports:
//   master : the environment (byte source plus text buffer)
//   slave  : the tty controller
// ---------------------------------------------------------------------------
interface vgacon_tty_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic [2:0]        in_color;
  logic              in_ready;

  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [6:0]        buf_wchar;
  logic [2:0]        buf_wcolor;
  logic [ADDR_W-1:0] buf_raddr;
  logic [6:0]        buf_rchar;
  logic [2:0]        buf_rcolor;

  modport master (
    output in_valid, in_data, in_color,
    input  in_ready,
    input  buf_we, buf_waddr, buf_wchar, buf_wcolor, buf_raddr,
    output buf_rchar, buf_rcolor
  );

  modport slave (
    input  in_valid, in_data, in_color,
    output in_ready,
    output buf_we, buf_waddr, buf_wchar, buf_wcolor, buf_raddr,
    input  buf_rchar, buf_rcolor
  );
endinterface

// File: rtl/vgacon_tty_ctrl.sv
// ---------------------------------------------------------------------------
// vgacon_tty_ctrl
// Terminal-style sequencer: turns a byte stream into writes on the VGA console
// text buffer. Tracks a cursor, decodes control codes (LF, CR, BS, FF) and
// runs multi-cycle scroll/clear sequences through the buffer ports.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   bus (slave)     byte handshake + buffer read/write port
//   vblank          vertical blank from the scan-out timing
//   cursor_col/row  current cursor position
//   busy            high whenever the sequencer is not idle
//
// Build option:
//   VGACON_VBLANK_SYNC_EN  when defined, scroll/fill/clear steps only advance
//                          (and write) while vblank is high, so bulk updates
//                          never tear the visible frame.
// ---------------------------------------------------------------------------
module vgacon_tty_ctrl #(
  parameter int         NUM_ROWS      = 3,
  parameter int         NUM_COLS      = 10,
  parameter int         ADDR_W        = 5,
  parameter logic [2:0] DEFAULT_COLOR = 3'b010,
  parameter logic [6:0] FILL_CHAR     = 7'h20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vgacon_tty_ctrl_if.slave            bus,
  input  logic                        vblank,
  output logic [$clog2(NUM_COLS)-1:0] cursor_col,
  output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
  output logic                        busy
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int CELLS = NUM_ROWS * NUM_COLS;

  localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] SCROLL_LAST =
    ADDR_W'(((NUM_ROWS > 1) ? (NUM_ROWS - 1) * NUM_COLS : 1) - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(NUM_COLS);
  localparam logic [COL_W-1:0]  COL_MAX     = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX     = ROW_W'(NUM_ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SCROLL,
    FILL,
    CLEAR
  } state_t;

  // A one-row buffer has nothing to copy, so a bottom-row newline goes
  // straight to the fill of the (only) last row.
  localparam state_t BOTTOM_NL_STATE = (NUM_ROWS > 1) ? SCROLL : FILL;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        byte_q;
  logic [2:0]        color_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;

  logic [ADDR_W-1:0] cursor_addr;
  logic              exec_nl;
  logic              step_en;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

`ifdef VGACON_VBLANK_SYNC_EN
  assign step_en = vblank;
`else
  // Bulk sequences free-run; vblank is intentionally not consulted.
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign step_en       = 1'b1;
`endif

  assign cursor_addr = ADDR_W'(row_q) * ROW_STRIDE + ADDR_W'(col_q);

  // A newline is either an explicit LF or the wrap after the last column.
  assign exec_nl = (byte_q == CH_LF) ||
                   (is_printable(byte_q) && (col_q == COL_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            byte_q  <= bus.in_data;
            color_q <= bus.in_color;
            state   <= EXEC;
          end
        end

        EXEC: begin
          state <= IDLE;
          idx   <= '0;
          if (is_printable(byte_q)) begin
            col_q <= (col_q == COL_MAX) ? '0 : col_q + 1'b1;
          end else begin
            case (byte_q)
              CH_CR: col_q <= '0;
              CH_BS: if (col_q != '0) col_q <= col_q - 1'b1;
              CH_FF: begin
                col_q <= '0;
                row_q <= '0;
                state <= CLEAR;
              end
              default: ;
            endcase
          end
          if (exec_nl) begin
            if (row_q != ROW_MAX) row_q <= row_q + 1'b1;
            else                  state <= BOTTOM_NL_STATE;
          end
        end

        // Copy row r+1 into row r, one cell per step. The last copy index
        // plus one is exactly the first cell of the bottom row.
        SCROLL: begin
          if (step_en) begin
            idx <= idx + 1'b1;
            if (idx == SCROLL_LAST) state <= FILL;
          end
        end

        FILL, CLEAR: begin
          if (step_en) begin
            if (idx == LAST_CELL) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Buffer port decode from the registered state/index. In SCROLL the write
  // data comes straight from the buffer read port, which answers in the same
  // cycle, so the copy needs no extra pipeline stage.
  always_comb begin
    bus.buf_we     = 1'b0;
    bus.buf_waddr  = idx;
    bus.buf_raddr  = '0;
    bus.buf_wchar  = FILL_CHAR;
    bus.buf_wcolor = DEFAULT_COLOR;
    case (state)
      EXEC: begin
        bus.buf_we     = is_printable(byte_q);
        bus.buf_waddr  = cursor_addr;
        bus.buf_wchar  = byte_q[6:0];
        bus.buf_wcolor = color_q;
      end
      SCROLL: begin
        bus.buf_we     = step_en;
        bus.buf_raddr  = idx + ROW_STRIDE;
        bus.buf_wchar  = bus.buf_rchar;
        bus.buf_wcolor = bus.buf_rcolor;
      end
      FILL, CLEAR: begin
        bus.buf_we = step_en;
      end
      default: ;
    endcase
  end

  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;

endmodule

// File: tb/tb_vgacon_tty_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vgacon_tty_ctrl
// Directed bench for vgacon_tty_ctrl (3x10 buffer). Provides a behavioural
// text buffer with a combinational read port, logs every buffer write and
// compares against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_vgacon_tty_ctrl;

  localparam int ADDR_W = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vblank;
  logic [3:0] cursor_col;
  logic [1:0] cursor_row;
  logic       busy;

  vgacon_tty_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  vgacon_tty_ctrl #(
    .NUM_ROWS(3),
    .NUM_COLS(10),
    .ADDR_W(ADDR_W),
    .DEFAULT_COLOR(3'b010),
    .FILL_CHAR(7'h20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .vblank(vblank),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural text buffer.
  logic [6:0] mem_char [0:31];
  logic [2:0] mem_col  [0:31];
  assign bus.buf_rchar  = mem_char[bus.buf_raddr];
  assign bus.buf_rcolor = mem_col[bus.buf_raddr];

  int         log_addr [$];
  int         log_char [$];
  int         log_col  [$];

  always @(posedge clk) begin
    if (bus.buf_we) begin
      mem_char[bus.buf_waddr] <= bus.buf_wchar;
      mem_col[bus.buf_waddr]  <= bus.buf_wcolor;
      log_addr.push_back(int'(bus.buf_waddr));
      log_char.push_back(int'(bus.buf_wchar));
      log_col.push_back(int'(bus.buf_wcolor));
    end
  end

  // Expected buffer contents built from the stimulus itself.
  logic [6:0] exp_char [0:31];
  logic [2:0] exp_col  [0:31];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Returns 1ns after the accepting edge, i.e. inside the EXEC cycle.
  task automatic send(input logic [7:0] b, input logic [2:0] c);
    wait_idle();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_color = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_wr(input int k, input int addr, input int ch, input int col);
    if (k < log_addr.size()) begin
      check($sformatf("wr%0d_addr", k), 32'(log_addr[k]), 32'(addr));
      check($sformatf("wr%0d_char", k), 32'(log_char[k]), 32'(ch));
      check($sformatf("wr%0d_col", k),  32'(log_col[k]),  32'(col));
    end else begin
      check($sformatf("wr%0d_present", k), 32'(log_addr.size()), 32'(k + 1));
    end
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check({tag, "_row"}, 32'(cursor_row), 32'(row));
    check({tag, "_col"}, 32'(cursor_col), 32'(col));
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_char.delete();
    log_col.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ch;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_color = 3'b000;
`ifdef VGACON_VBLANK_SYNC_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_we",       32'(bus.buf_we), 32'd0);
    check("rst_waddr",    32'(bus.buf_waddr), 32'd0);
    check("rst_raddr",    32'(bus.buf_raddr), 32'd0);
    check_cursor("rst", 0, 0);

    // Single printable char 'A', colour 4
    clear_log();
    send(8'h41, 3'b100);
    check("A_we",       32'(bus.buf_we), 32'd1);
    check("A_waddr",    32'(bus.buf_waddr), 32'd0);
    check("A_wchar",    32'(bus.buf_wchar), 32'h41);
    check("A_wcolor",   32'(bus.buf_wcolor), 32'd4);
    check("A_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("A_ready_back", 32'(bus.in_ready), 32'd1);
    check_cursor("A", 0, 1);
    exp_char[0] = 7'h41;
    exp_col[0]  = 3'b100;

    // Complete the first row: 'B'..'J' at addrs 1..9, wrap to (1,0)
    for (int k = 1; k < 10; k++) begin
      ch = 8'h41 + 8'(k);
      exp_char[k] = ch[6:0];
      exp_col[k]  = 3'(k);
      send(ch, 3'(k));
    end
    step();
    check_cursor("row0", 1, 0);
    check("row0_busy", 32'(busy), 32'd0);
    check("row0_nwr", 32'(log_addr.size()), 32'd10);
    for (int k = 0; k < 10; k++) check_wr(k, k, int'(exp_char[k]), int'(exp_col[k]));

    // Fill rows 1 and 2 up to (2,9)
    for (int k = 0; k < 19; k++) begin
      ch = 8'h61 + 8'(k);
      exp_char[10 + k] = ch[6:0];
      exp_col[10 + k]  = 3'(k + 5);
      send(ch, 3'(k + 5));
    end
    step();
    check_cursor("pre_scroll", 2, 9);

    // 'Z' at the bottom-right corner triggers a scroll
    clear_log();
    send(8'h5A, 3'b001);
    exp_char[29] = 7'h5A;
    exp_col[29]  = 3'b001;
    n = 0;
    step();
    while (busy && n < 100) begin
      n++;
      step();
    end
    check("scroll_busy_cycles", 32'(n), 32'd30);
    check_cursor("scroll", 2, 0);
    check("scroll_nwr", 32'(log_addr.size()), 32'd31);
    check_wr(0, 29, 32'h5A, 1);
    for (int i = 0; i < 20; i++) check_wr(1 + i, i, int'(exp_char[i + 10]), int'(exp_col[i + 10]));
    for (int j = 0; j < 10; j++) check_wr(21 + j, 20 + j, 32'h20, 2);

    // Form feed: clear whole buffer, cursor home
    clear_log();
    send(8'h0C, 3'b111);
    check("ff_exec_we", 32'(bus.buf_we), 32'd0);
    wait_idle();
    check_cursor("ff", 0, 0);
    check("ff_nwr", 32'(log_addr.size()), 32'd30);
    for (int i = 0; i < 30; i++) check_wr(i, i, 32'h20, 2);

    // Reset in the middle of a clear
    send(8'h41, 3'b011);
    step();
    check_cursor("pre_rst", 0, 1);
    clear_log();
    send(8'h0C, 3'b000);
    repeat (13) step();
    check("midclr_waddr", 32'(bus.buf_waddr), 32'd12);
    check("midclr_we",    32'(bus.buf_we), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("postrst_busy",  32'(busy), 32'd0);
    check("postrst_we",    32'(bus.buf_we), 32'd0);
    check("postrst_ready", 32'(bus.in_ready), 32'd1);
    check("postrst_waddr", 32'(bus.buf_waddr), 32'd0);
    check_cursor("postrst", 0, 0);
    step();
    check("midclr_nwr", 32'(log_addr.size()), 32'd13);

    // Control codes: move to (1,5), then BS, CR, BS, BEL, 0x85
    send(8'h0A, 3'b000);
    for (int k = 0; k < 5; k++) send(8'h76, 3'b110);
    step();
    check_cursor("pre_bs", 1, 5);
    clear_log();
    send(8'h08, 3'b000);
    step();
    check_cursor("bs1", 1, 4);
    send(8'h0D, 3'b000);
    step();
    check_cursor("cr", 1, 0);
    send(8'h08, 3'b000);
    step();
    check_cursor("bs0", 1, 0);
    send(8'h07, 3'b000);
    step();
    check_cursor("bel", 1, 0);
    send(8'h85, 3'b000);
    step();
    check_cursor("hi", 1, 0);
    check("ctl_nwr", 32'(log_addr.size()), 32'd0);

`ifdef VGACON_VBLANK_SYNC_EN
    // Clear gated by vblank
    vblank = 1'b0;
    clear_log();
    send(8'h0C, 3'b000);
    repeat (5) step();
    check("vb_hold_nwr",  32'(log_addr.size()), 32'd0);
    check("vb_hold_busy", 32'(busy), 32'd1);
    check("vb_hold_we",   32'(bus.buf_we), 32'd0);
    @(negedge clk);
    vblank = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vblank = 1'b0;
    check("vb_pause_nwr",   32'(log_addr.size()), 32'd5);
    check("vb_pause_we",    32'(bus.buf_we), 32'd0);
    check("vb_pause_waddr", 32'(bus.buf_waddr), 32'd5);
    repeat (3) step();
    check("vb_still_nwr", 32'(log_addr.size()), 32'd5);
    vblank = 1'b1;
    #1;
    check("vb_resume_we",    32'(bus.buf_we), 32'd1);
    check("vb_resume_waddr", 32'(bus.buf_waddr), 32'd5);
    wait_idle();
    check("vb_nwr", 32'(log_addr.size()), 32'd30);
    check_wr(5, 5, 32'h20, 2);
    check_wr(29, 29, 32'h20, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
